// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point format and GBM Monte-Carlo defaults for the pricing fabric.
package fpga_cfg_pkg;

  localparam int FP_WIDTH = 32;
  localparam int FP_QFRAC = 16;

  localparam int GBM_NUM_PATHS = 8;
  localparam int GBM_N_STEPS   = 16;

  // Per-run model parameters, latched once and shared with the step datapath.
  typedef struct packed {
    logic [FP_WIDTH-1:0] r;
    logic [FP_WIDTH-1:0] sigma;
    logic [FP_WIDTH-1:0] dt;
  } gbm_params_t;

endpackage

// File: rtl/gbm_path_sequencer.sv
// Round-robin issue of GBM step transactions over NUM_PATHS interleaved paths,
// feeding each returned price back as that path's next spot and streaming
// every (path, step, price) record downstream.
module gbm_path_sequencer
  import fpga_cfg_pkg::*;
#(
  parameter int WIDTH     = FP_WIDTH,
  parameter int QFRAC     = FP_QFRAC,
  parameter int NUM_PATHS = GBM_NUM_PATHS,
  parameter int N_STEPS   = GBM_N_STEPS,
  localparam int PW       = (NUM_PATHS > 1) ? $clog2(NUM_PATHS) : 1,
  localparam int SW       = $clog2(N_STEPS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] S0,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] sigma,
  input  logic [WIDTH-1:0] dt,
  input  logic             z_valid,
  output logic             z_ready,
  input  logic [WIDTH-1:0] z_in,
  output logic             step_valid,
  input  logic             step_ready,
  output logic [WIDTH-1:0] step_z,
  output logic [WIDTH-1:0] step_S,
  output logic [WIDTH-1:0] step_r,
  output logic [WIDTH-1:0] step_sigma,
  output logic [WIDTH-1:0] step_dt,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [WIDTH-1:0] res_S,
  output logic             path_valid,
  input  logic             path_ready,
  output logic [PW-1:0]    path_idx,
  output logic [SW-1:0]    step_idx,
  output logic [WIDTH-1:0] path_S,
  output logic             path_last,
  output logic             busy,
  output logic             done
);

  if (QFRAC >= WIDTH) begin : g_bad_fmt
    $error("gbm_path_sequencer: QFRAC must be smaller than WIDTH");
  end

  localparam logic [PW-1:0] LAST_PATH = PW'(NUM_PATHS - 1);
  localparam logic [SW-1:0] STEPS     = SW'(N_STEPS);
  localparam logic [SW-1:0] LAST_STEP = SW'(N_STEPS - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t               r_state;
  logic [PW-1:0]        r_issue_path;
  logic [SW-1:0]        r_issue_step;
  logic [PW-1:0]        r_ret_path;
  logic [SW-1:0]        r_ret_step;
  logic [NUM_PATHS-1:0] r_pending;
  logic [WIDTH-1:0]     r_r;
  logic [WIDTH-1:0]     r_sigma;
  logic [WIDTH-1:0]     r_dt;
  logic                 r_done;
  logic [WIDTH-1:0]     r_smem [NUM_PATHS];

  logic                 w_run;
  logic                 w_can_issue;
  logic                 w_fire;
  logic                 w_ret_hs;
  logic                 w_last_rec;
  logic [NUM_PATHS-1:0] w_set;
  logic [NUM_PATHS-1:0] w_clr;

  // Issue/return qualification; all outputs are forced low outside RUN.
  always_comb begin
    w_run       = (r_state == ST_RUN);
    w_can_issue = w_run && !r_pending[r_issue_path] && (r_issue_step < STEPS);
    w_fire      = w_can_issue && z_valid && step_ready;
    w_ret_hs    = w_run && res_valid && path_ready;
    w_last_rec  = (r_ret_path == LAST_PATH) && (r_ret_step == LAST_STEP);
    w_set       = w_fire   ? (NUM_PATHS'(1) << r_issue_path) : '0;
    w_clr       = w_ret_hs ? (NUM_PATHS'(1) << r_ret_path)   : '0;
  end

  // Transaction payload and downstream record, pass-through from current state.
  always_comb begin
    step_valid = w_can_issue && z_valid;
    z_ready    = w_can_issue && step_ready;
    step_z     = w_run ? z_in : '0;
    step_S     = w_run ? r_smem[r_issue_path] : '0;
    step_r     = r_r;
    step_sigma = r_sigma;
    step_dt    = r_dt;
    res_ready  = w_run && path_ready;
    path_valid = w_run && res_valid;
    path_idx   = w_run ? r_ret_path : '0;
    step_idx   = w_run ? r_ret_step + SW'(1) : '0;
    path_S     = w_run ? res_S : '0;
    path_last  = w_run && w_last_rec;
    busy       = w_run;
    done       = r_done;
  end

  // Run control FSM: parameter latch, issue/return counters, pending flags.
  // A path is only issued while its pending bit is clear, so the set and clear
  // masks never hit the same bit in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_issue_path <= '0;
      r_issue_step <= '0;
      r_ret_path   <= '0;
      r_ret_step   <= '0;
      r_pending    <= '0;
      r_r          <= '0;
      r_sigma      <= '0;
      r_dt         <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_RUN;
            r_r          <= r;
            r_sigma      <= sigma;
            r_dt         <= dt;
            r_issue_path <= '0;
            r_issue_step <= '0;
            r_ret_path   <= '0;
            r_ret_step   <= '0;
            r_pending    <= '0;
          end
        end
        ST_RUN: begin
          r_pending <= (r_pending | w_set) & ~w_clr;
          if (w_fire) begin
            if (r_issue_path == LAST_PATH) begin
              r_issue_path <= '0;
              r_issue_step <= r_issue_step + SW'(1);
            end else begin
              r_issue_path <= r_issue_path + PW'(1);
            end
          end
          if (w_ret_hs) begin
            if (r_ret_path == LAST_PATH) begin
              r_ret_path <= '0;
              r_ret_step <= r_ret_step + SW'(1);
            end else begin
              r_ret_path <= r_ret_path + PW'(1);
            end
            if (w_last_rec) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Per-path spot store: seeded with S0 on start, overwritten by each result.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && start) begin
      for (int unsigned p = 0; p < NUM_PATHS; p++) begin
        r_smem[p] <= S0;
      end
    end else if (w_ret_hs) begin
      r_smem[r_ret_path] <= res_S;
    end
  end

endmodule

// File: doc/gbm_path_sequencer.md
Name: gbm_path_sequencer

Overview:
- Master-side driver for the GBM step datapath: issues per-step transactions (z, S, r, sigma, dt) and consumes the returned S_next.
- Interleaves NUM_PATHS independent Monte-Carlo paths round-robin to hide step-pipeline latency.
- Feeds each returned price back as that path's next S, and streams every (path, step, price) to the downstream LSM regression/path store.

Parameters:
- WIDTH, fpga_cfg_pkg::FP_WIDTH, signed fixed-point word width.
- QFRAC, fpga_cfg_pkg::FP_QFRAC, fractional bits (format only; no arithmetic performed here).
- NUM_PATHS, 8, paths interleaved per run (>=1, power of 2 not required).
- N_STEPS, 16, time steps per path (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a run; ignored unless IDLE
- S0  in  WIDTH  initial spot, latched on accepted start
- r  in  WIDTH  rate, latched on accepted start
- sigma  in  WIDTH  volatility, latched on accepted start
- dt  in  WIDTH  step size, latched on accepted start
- z_valid  in  1  normal-shock stream valid (QMC/inverse-CDF source)
- z_ready  out  1  shock consumed
- z_in  in  WIDTH  standard normal shock
- step_valid  out  1  transaction to step datapath
- step_ready  in  1  step datapath accepts
- step_z, step_S, step_r, step_sigma, step_dt  out  WIDTH each  transaction payload
- res_valid  in  1  S_next available from step datapath
- res_ready  out  1  S_next accepted
- res_S  in  WIDTH  S_next
- path_valid  out  1  output record valid
- path_ready  in  1  downstream accepts
- path_idx  out  $clog2(NUM_PATHS) (min 1)  path of record
- step_idx  out  $clog2(N_STEPS+1)  step number, 1..N_STEPS
- path_S  out  WIDTH  price after step_idx
- path_last  out  1  final record of run
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after last record accepted

Behaviour:
- Reset: state=IDLE; all outputs 0; pending[] cleared; counters 0; S_mem contents don't-care.
- States: IDLE -> RUN on start; RUN -> IDLE on final output handshake, with done=1 in that same cycle (registered: done asserted the cycle after the handshake, for exactly one cycle).
- On start: latch S0/r/sigma/dt; S_mem[p]=S0 for all p (write-all, or valid bits cleared meaning "use S0"); issue_path=issue_step=ret_path=ret_step=0.
- Issue rule: can_issue = RUN & ~pending[issue_path] & (issue_step < N_STEPS).
  - step_valid = can_issue & z_valid.
  - z_ready = can_issue & step_ready.
  - Fire = both high. Same cycle z is consumed; no z is ever consumed without a step issue.
- Fire effects: pending[issue_path]=1; issue_path++ wrapping at NUM_PATHS; on wrap, issue_step++.
- Payload: step_S = S_mem[issue_path]; step_z = z_in; r/sigma/dt from latched copies. Payload is combinational from current state and z_in, stable while step_valid is held.
- No combinational path from step_valid to step_ready or from res_valid to res_ready. The step datapath must not make ready depend on valid.
- Return: results arrive strictly in issue order; ret_path/ret_step track them identically to the issue counters.
  - res_ready = path_ready; path_valid = res_valid & RUN. Pass-through, zero latency.
  - path_idx = ret_path; step_idx = ret_step+1; path_S = res_S.
  - path_last = (ret_path==NUM_PATHS-1) & (ret_step==N_STEPS-1).
- Return handshake: S_mem[ret_path] = res_S; pending[ret_path] cleared; counters advance.
- Simultaneous issue and return on the same path index: the return's pending-clear wins. The issue that cycle saw pending=1 and so did not fire; the read is from the old S_mem. No bypass.
- Max outstanding = NUM_PATHS. If pipeline latency < NUM_PATHS issue cycles, issue is never blocked by pending.
- Results with res_valid while IDLE: res_ready=0 (protocol error; not expected).
- Arithmetic: none; S values are copied bit-exact, and negative/zero S is passed through unchanged.
- start while busy: ignored. Reset mid-run: abort immediately to IDLE, with no done pulse. The step datapath must be reset by the same rst_n.

Decomposition:
- fpga_cfg_pkg supplies FP_WIDTH/FP_QFRAC.
- Add to fpga_cfg_pkg:
  - gbm_params_t (packed r, sigma, dt), shared with the step block.
  - Defaults GBM_NUM_PATHS, GBM_N_STEPS.
- No sub-module. S_mem is an inferred NUM_PATHS x WIDTH register array (distributed RAM acceptable).

Test Plan:
- NUM_PATHS=4, N_STEPS=3, S0=1.0, stub step returns S+z after fixed latency 2, z=0.25 constant, always ready -> 12 records: path p step k with S = 1.0+0.25k; path_last on (3,3); done one cycle later.
- Stub latency 10 > NUM_PATHS=4 -> issue stalls with z_ready=0 while pending; z consumed count exactly 12; no z dropped; records identical to the latency-2 case.
- path_ready toggled randomly (50%) -> res_ready mirrors it; no record lost or duplicated; S feedback per path correct (path p step k S = 1.0+0.25k).
- z_valid deasserted for 5 cycles mid-run -> step_valid=0 during the gap; step payload stays stable while step_ready=0; run completes with correct values.
- start pulsed during RUN with S0=2.0 -> ignored; all outputs use the original S0=1.0.
- rst_n asserted at record 5 -> busy=0 and all outputs 0 asynchronously; a new start after release gives a full correct run from step 1.
